// File: rtl/hnm_ssid_feeder_pkg.sv
// ============================================================================
// hxmpp_pkg : shared types and widths for the HNMPP hit-map front end
// Rev 1.0
// ============================================================================
`default_nettype none

package hxmpp_pkg;

   localparam int HNM_ROWS           = 256;
   localparam int SSID_WIDTH_DEFAULT = $clog2(HNM_ROWS);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_CLEAR = 2'd1,
      CLEAR      = 2'd2
   } feeder_state_t;

   typedef struct packed {
      logic                          last;
      logic [SSID_WIDTH_DEFAULT-1:0] ssid;
   } ssid_entry_t;

endpackage

`default_nettype wire

// File: rtl/hnm_ssid_feeder_if.sv
// ============================================================================
// hnm_ssid_feeder_if : SSID input stream, hit-map write port and clear handshake
// Rev 1.0
// ============================================================================
`default_nettype none

interface hnm_ssid_feeder_if
   import hxmpp_pkg::*;
#(
   parameter int SSID_WIDTH = SSID_WIDTH_DEFAULT,
   parameter int CNT_WIDTH  = 9
);
   logic [SSID_WIDTH-1:0] in_ssid;
   logic                  in_last;
   logic                  in_valid;
   logic                  in_ready;
   logic                  hnm_write_ready;
   logic [SSID_WIDTH-1:0] hnm_ssid_write;
   logic                  hnm_write;
   logic                  hnm_reset;
   logic                  clear_req;
   logic                  event_done;
   logic [CNT_WIDTH-1:0]  event_ssid_count;

   // Feeder side
   modport slave (
      input  in_ssid, in_last, in_valid, hnm_write_ready, clear_req,
      output in_ready, hnm_ssid_write, hnm_write, hnm_reset, event_done, event_ssid_count
   );

   // Source / hit-map side
   modport master (
      output in_ssid, in_last, in_valid, hnm_write_ready, clear_req,
      input  in_ready, hnm_ssid_write, hnm_write, hnm_reset, event_done, event_ssid_count
   );
endinterface

`default_nettype wire

// File: rtl/hnm_ssid_feeder_fifo.sv
// ============================================================================
// ssid_fifo : synchronous FIFO with registered full/empty, no bypass
// Rev 1.0
// ============================================================================
`default_nettype none

module ssid_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             push,
   input  wire logic [WIDTH-1:0] din,
   input  wire logic             pop,
   output logic      [WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_cnt;
   logic [AW:0]      w_cnt_next;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign dout      = r_mem[r_rd_ptr];

   always_comb begin
      w_cnt_next = r_cnt;
      case ({w_do_push, w_do_pop})
         2'b10:   w_cnt_next = r_cnt + 1'b1;
         2'b01:   w_cnt_next = r_cnt - 1'b1;
         default: w_cnt_next = r_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_cnt <= w_cnt_next;
         full  <= (w_cnt_next == C_FULL_CNT);
         empty <= (w_cnt_next == '0);
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end
endmodule

`default_nettype wire

// File: rtl/hnm_ssid_feeder.sv
// ============================================================================
// hnm_ssid_feeder : buffers hit SSIDs, writes them to the hit map, sequences clears
// Rev 1.0
// ============================================================================
`default_nettype none

module hnm_ssid_feeder
   import hxmpp_pkg::*;
#(
   parameter int SSID_WIDTH = SSID_WIDTH_DEFAULT,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 9
) (
   input wire logic         clk,
   input wire logic         reset,
   hnm_ssid_feeder_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

   feeder_state_t         r_state;
   logic [SSID_WIDTH-1:0] r_ssid_write;
   logic                  r_write;
   logic                  r_hnm_reset;
   logic                  r_event_done;
   logic [CNT_WIDTH-1:0]  r_count;

   ssid_entry_t w_push_entry;
   ssid_entry_t w_pop_entry;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;

   assign w_push_entry = '{last: bus.in_last, ssid: bus.in_ssid};
   assign w_pop        = (r_state == RUN) && !w_empty && bus.hnm_write_ready;

   ssid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(ssid_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.in_valid),
      .din   (w_push_entry),
      .pop   (w_pop),
      .dout  (w_pop_entry),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= RUN;
         r_ssid_write <= '0;
         r_write      <= 1'b0;
         r_hnm_reset  <= 1'b1;
         r_event_done <= 1'b0;
         r_count      <= '0;
      end else begin
         r_write      <= w_pop;
         r_event_done <= 1'b0;
         r_hnm_reset  <= 1'b0;
         if (w_pop) begin
            r_ssid_write <= w_pop_entry.ssid;
            if (r_count != C_CNT_MAX) r_count <= r_count + 1'b1;
         end
         case (r_state)
            RUN: begin
               if (w_pop && w_pop_entry.last) begin
                  r_state      <= WAIT_CLEAR;
                  r_event_done <= 1'b1;
               end
            end
            WAIT_CLEAR: begin
               // hnm_reset is registered on entry so it is high exactly while in CLEAR.
               if (bus.clear_req) begin
                  r_state     <= CLEAR;
                  r_hnm_reset <= 1'b1;
               end
            end
            CLEAR: begin
               r_state <= RUN;
               r_count <= '0;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign bus.in_ready         = !w_full;
   assign bus.hnm_ssid_write   = r_ssid_write;
   assign bus.hnm_write        = r_write;
   assign bus.hnm_reset        = r_hnm_reset;
   assign bus.event_done       = r_event_done;
   assign bus.event_ssid_count = r_count;
endmodule

`default_nettype wire

// File: tb/tb_hnm_ssid_feeder.sv
// ============================================================================
// tb_hnm_ssid_feeder : directed self-checking bench for hnm_ssid_feeder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hnm_ssid_feeder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      logic [7:0] ssid;
      int         cyc;
      logic       done;
      logic [8:0] cnt;
   } wr_t;

   wr_t wq[$];
   int  rq[$];

   hnm_ssid_feeder_if #(.SSID_WIDTH(8), .CNT_WIDTH(9)) bus ();

   hnm_ssid_feeder #(.SSID_WIDTH(8), .FIFO_DEPTH(16), .CNT_WIDTH(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.hnm_write)
         wq.push_back('{ssid: bus.hnm_ssid_write, cyc: cyc, done: bus.event_done, cnt: bus.event_ssid_count});
      if (bus.hnm_reset) rq.push_back(cyc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one word and waits (bounded) until it is accepted; returns the accepting edge.
   task automatic push(input logic [7:0] s, input logic l, output int acc_cyc);
      logic acc;
      int   n;
      bus.in_valid = 1'b1;
      bus.in_ssid  = s;
      bus.in_last  = l;
      n = 0;
      acc_cyc = -1;
      do begin
         acc = bus.in_ready;
         tick();
         n++;
      end while (!acc && n < 40);
      if (acc) acc_cyc = cyc;
      else chk("push_timeout", 32'(s), 32'hFFFF_FFFF);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic do_clear();
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      tick();
      tick();
   endtask

   int a0, dummy, d, n;

   initial begin
      bus.in_ssid = '0;
      bus.in_last = 1'b0;
      bus.in_valid = 1'b0;
      bus.hnm_write_ready = 1'b1;
      bus.clear_req = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_hnm_reset", 32'(bus.hnm_reset), 1);
      chk("rst_write", 32'(bus.hnm_write), 0);
      chk("rst_ssid", 32'(bus.hnm_ssid_write), 0);
      chk("rst_done", 32'(bus.event_done), 0);
      chk("rst_count", 32'(bus.event_ssid_count), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      reset = 1'b0;
      tick();
      chk("post_rst_hnm_reset", 32'(bus.hnm_reset), 0);
      wq.delete();
      rq.delete();

      // Basic event
      push(8'h05, 1'b0, a0);
      push(8'h1A, 1'b0, dummy);
      push(8'h3F, 1'b1, dummy);
      idle();
      repeat (6) tick();
      chk("t1_nwr", wq.size(), 3);
      if (wq.size() == 3) begin
         chk("t1_latency", wq[0].cyc, a0 + 1);
         chk("t1_w0", 32'(wq[0].ssid), 32'h05);
         chk("t1_w1", 32'(wq[1].ssid), 32'h1A);
         chk("t1_w2", 32'(wq[2].ssid), 32'h3F);
         chk("t1_consec", wq[2].cyc - wq[0].cyc, 2);
         chk("t1_done_early", 32'({wq[0].done, wq[1].done}), 0);
         chk("t1_done", 32'(wq[2].done), 1);
         chk("t1_count", 32'(wq[2].cnt), 3);
      end
      chk("t1_no_reset", rq.size(), 0);
      do_clear();
      chk("t1_clear_pulse", rq.size(), 1);
      chk("t1_count_zero", 32'(bus.event_ssid_count), 0);
      wq.delete();
      rq.delete();

      // Backpressure
      bus.hnm_write_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h10 + i), (i == 3), dummy);
      idle();
      repeat (5) tick();
      chk("t2_stall", wq.size(), 0);
      bus.hnm_write_ready = 1'b1;
      repeat (8) tick();
      chk("t2_nwr", wq.size(), 4);
      if (wq.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("t2_order", 32'(wq[i].ssid), 32'(8'h10 + i));
         chk("t2_count", 32'(wq[3].cnt), 4);
         chk("t2_done", 32'(wq[3].done), 1);
      end
      do_clear();
      wq.delete();
      rq.delete();

      // Ignored clear mid-event
      bus.hnm_write_ready = 1'b0;
      push(8'h20, 1'b0, dummy);
      idle();
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      repeat (3) tick();
      chk("t5_no_reset", rq.size(), 0);
      bus.hnm_write_ready = 1'b1;
      push(8'h21, 1'b1, dummy);
      idle();
      repeat (5) tick();
      chk("t5_nwr", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("t5_w0", 32'(wq[0].ssid), 32'h20);
         chk("t5_done0", 32'(wq[0].done), 0);
         chk("t5_count", 32'(wq[1].cnt), 2);
      end
      do_clear();
      wq.delete();
      rq.delete();

      // Full FIFO
      bus.hnm_write_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(8'h40 + i), 1'b0, dummy);
      chk("t3_full", 32'(bus.in_ready), 0);
      bus.in_valid = 1'b1;
      bus.in_ssid  = 8'h50;
      bus.in_last  = 1'b0;
      repeat (3) tick();
      chk("t3_held", 32'(bus.in_ready), 0);
      chk("t3_stall", wq.size(), 0);
      bus.hnm_write_ready = 1'b1;
      for (int i = 16; i < 20; i++) push(8'(8'h40 + i), (i == 19), dummy);
      idle();
      repeat (25) tick();
      chk("t3_nwr", wq.size(), 20);
      if (wq.size() == 20) begin
         n = 0;
         for (int i = 0; i < 20; i++) if (wq[i].ssid != 8'(8'h40 + i)) n++;
         chk("t3_order_errs", n, 0);
         chk("t3_count", 32'(wq[19].cnt), 20);
      end
      do_clear();
      wq.delete();
      rq.delete();

      // Event boundary
      push(8'h01, 1'b0, dummy);
      push(8'h02, 1'b1, dummy);
      push(8'h03, 1'b1, dummy);
      idle();
      n = 0;
      while (!bus.event_done && n < 20) begin
         tick();
         n++;
      end
      chk("t4_done_seen", 32'(bus.event_done), 1);
      d = cyc;
      repeat (3) tick();
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      repeat (6) tick();
      chk("t4_nreset", rq.size(), 1);
      chk("t4_nwr", wq.size(), 3);
      if (rq.size() == 1 && wq.size() == 3) begin
         chk("t4_reset_cyc", rq[0], d + 4);
         chk("t4_b_ssid", 32'(wq[2].ssid), 32'h03);
         chk("t4_b_cyc", wq[2].cyc, rq[0] + 2);
         chk("t4_b_count", 32'(wq[2].cnt), 1);
         chk("t4_b_done", 32'(wq[2].done), 1);
      end
      do_clear();
      wq.delete();
      rq.delete();

      // Reset mid-event
      bus.hnm_write_ready = 1'b0;
      push(8'h07, 1'b0, dummy);
      push(8'h08, 1'b0, dummy);
      idle();
      reset = 1'b1;
      tick();
      chk("t6_hnm_reset", 32'(bus.hnm_reset), 1);
      chk("t6_count", 32'(bus.event_ssid_count), 0);
      reset = 1'b0;
      tick();
      chk("t6_hnm_reset_off", 32'(bus.hnm_reset), 0);
      bus.hnm_write_ready = 1'b1;
      repeat (5) tick();
      chk("t6_no_write", wq.size(), 0);
      chk("t6_count_after", 32'(bus.event_ssid_count), 0);
      chk("t6_in_ready", 32'(bus.in_ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
